// File: rtl/llc_rst_flush_seq.sv
// llc_rst_flush_seq
// Drives the LLC register block's reset/flush walk. After reset the regs raise
// rst_stall and every set is written all-ways-invalid. On flush, each set is
// read, every dirty way is written back over a valid/ready channel and then
// invalidated. The set counter itself lives in the regs; this block only
// requests increments and clears. A soft reset (rst_state) aborts any walk.
module llc_rst_flush_seq #(
    parameter int SET_BITS = 8,
    parameter int WAYS     = 16,
    parameter int WAY_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_state,
    input  logic                rst_stall,
    input  logic                flush_stall,
    input  logic [SET_BITS-1:0] rst_flush_stalled_set,
    input  logic [WAYS-1:0]     dirty_mask,
    input  logic                wb_ready,
    output logic                rd_set_req,
    output logic                wr_set_inv,
    output logic                wr_way_inv,
    output logic                wb_valid,
    output logic [WAY_BITS-1:0] wb_way,
    output logic                incr_rst_flush_stalled_set,
    output logic                clr_rst_flush_stalled_set,
    output logic                clr_rst_stall,
    output logic                clr_flush_stall,
    output logic                walk_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_WR  = 3'd1,
        FL_RD   = 3'd2,
        FL_CAP  = 3'd3,
        FL_SCAN = 3'd4,
        FL_WB   = 3'd5,
        FL_NEXT = 3'd6
    } state_t;

    localparam logic [SET_BITS-1:0] LAST_SET = {SET_BITS{1'b1}};

    state_t              state_reg, state_next;
    logic [WAYS-1:0]     pending_reg, pending_next;
    logic [WAY_BITS-1:0] way_reg, way_next;
    logic [WAY_BITS-1:0] lowest_way;
    logic                last_set;

    assign last_set = (rst_flush_stalled_set == LAST_SET);
    assign wb_way   = way_reg;

    // Priority encoder: index of the lowest still-dirty way in the captured mask.
    always_comb begin
        lowest_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                lowest_way = WAY_BITS'(i);
            end
        end
    end

    // State, pending-writeback mask and current writeback way registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            way_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            way_reg     <= way_next;
        end
    end

    // Next-state logic; a soft reset overrides everything and drops pending work.
    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        way_next     = way_reg;
        if (rst_state) begin
            state_next   = IDLE;
            pending_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Reset walk wins; a flush raised meanwhile waits here.
                    if (rst_stall) begin
                        state_next = RST_WR;
                    end else if (flush_stall) begin
                        state_next = FL_RD;
                    end
                end
                RST_WR: begin
                    if (last_set) begin
                        state_next = IDLE;
                    end
                end
                FL_RD: begin
                    state_next = FL_CAP;
                end
                FL_CAP: begin
                    // Dirty bits arrive one cycle after the read request.
                    pending_next = dirty_mask;
                    state_next   = FL_SCAN;
                end
                FL_SCAN: begin
                    if (pending_reg == '0) begin
                        state_next = FL_NEXT;
                    end else begin
                        way_next   = lowest_way;
                        state_next = FL_WB;
                    end
                end
                FL_WB: begin
                    if (wb_ready) begin
                        pending_next[way_reg] = 1'b0;
                        state_next            = FL_SCAN;
                    end
                end
                FL_NEXT: begin
                    state_next = last_set ? IDLE : FL_RD;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state; all strobes suppressed during soft reset.
    always_comb begin
        rd_set_req                 = 1'b0;
        wr_set_inv                 = 1'b0;
        wr_way_inv                 = 1'b0;
        wb_valid                   = 1'b0;
        incr_rst_flush_stalled_set = 1'b0;
        clr_rst_flush_stalled_set  = 1'b0;
        clr_rst_stall              = 1'b0;
        clr_flush_stall            = 1'b0;
        walk_done                  = 1'b0;
        if (!rst_state) begin
            case (state_reg)
                RST_WR: begin
                    wr_set_inv = 1'b1;
                    if (last_set) begin
                        clr_rst_flush_stalled_set = 1'b1;
                        clr_rst_stall             = 1'b1;
                        walk_done                 = 1'b1;
                    end else begin
                        incr_rst_flush_stalled_set = 1'b1;
                    end
                end
                FL_RD: begin
                    rd_set_req = 1'b1;
                end
                FL_WB: begin
                    // Invalidate the way in the same cycle the writeback is accepted.
                    wb_valid   = 1'b1;
                    wr_way_inv = wb_ready;
                end
                FL_NEXT: begin
                    if (last_set) begin
                        clr_rst_flush_stalled_set = 1'b1;
                        clr_flush_stall           = 1'b1;
                        walk_done                 = 1'b1;
                    end else begin
                        incr_rst_flush_stalled_set = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// Bench for llc_rst_flush_seq with SET_BITS=3. A small model of the register
// block owns the set counter and the stall flags; a scoreboard queue holds the
// expected (set, way) writebacks, filled when a set's dirty mask is served and
// drained as the DUT invalidates ways.
module tb_llc_rst_flush_seq;

    localparam int SET_BITS = 3;
    localparam int WAYS     = 16;
    localparam int WAY_BITS = 4;
    localparam int SETS     = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                rst_state = 1'b0;
    logic                wb_ready = 1'b1;
    logic                flush_req = 1'b0;
    logic                rst_stall;
    logic                flush_stall;
    logic [SET_BITS-1:0] set_cnt;
    logic [WAYS-1:0]     dirty_mask;

    logic                rd_set_req, wr_set_inv, wr_way_inv, wb_valid;
    logic [WAY_BITS-1:0] wb_way;
    logic                incr, clr_cnt, clr_rst_stall, clr_flush_stall, walk_done;
    logic [8:0]          strobes;

    logic [WAYS-1:0]     mem [SETS];

    int n_checks = 0;
    int n_fail   = 0;

    assign strobes = {rd_set_req, wr_set_inv, wr_way_inv, wb_valid, incr,
                      clr_cnt, clr_rst_stall, clr_flush_stall, walk_done};

    always #5 clk = ~clk;

    llc_rst_flush_seq #(
        .SET_BITS(SET_BITS),
        .WAYS    (WAYS),
        .WAY_BITS(WAY_BITS)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .rst_state                 (rst_state),
        .rst_stall                 (rst_stall),
        .flush_stall               (flush_stall),
        .rst_flush_stalled_set     (set_cnt),
        .dirty_mask                (dirty_mask),
        .wb_ready                  (wb_ready),
        .rd_set_req                (rd_set_req),
        .wr_set_inv                (wr_set_inv),
        .wr_way_inv                (wr_way_inv),
        .wb_valid                  (wb_valid),
        .wb_way                    (wb_way),
        .incr_rst_flush_stalled_set(incr),
        .clr_rst_flush_stalled_set (clr_cnt),
        .clr_rst_stall             (clr_rst_stall),
        .clr_flush_stall           (clr_flush_stall),
        .walk_done                 (walk_done)
    );

    // Register-block model: stall flags, set counter and per-set dirty mask read port.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_stall   <= 1'b1;
            flush_stall <= 1'b0;
            set_cnt     <= '0;
            dirty_mask  <= '0;
        end else begin
            if (rst_state) begin
                rst_stall   <= 1'b1;
                flush_stall <= 1'b0;
                set_cnt     <= '0;
            end else begin
                if (clr_rst_stall) rst_stall <= 1'b0;
                if (flush_req) flush_stall <= 1'b1;
                else if (clr_flush_stall) flush_stall <= 1'b0;
                if (clr_cnt) set_cnt <= '0;
                else if (incr) set_cnt <= set_cnt + 3'd1;
            end
            if (rd_set_req) dirty_mask <= mem[set_cnt];
        end
    end

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (strobes !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_strobes: got %b expected %b", strobes, 9'd0);
            end
            n_checks++;
            if (wb_way !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_wb_way: got %0d expected 0", wb_way);
            end
        end
    endtask

    task automatic test_power_on();
        int  exp_q[$];
        int  e;
        int  n_wr = 0;
        int  guard = 0;
        bit  done = 1'b0;
        for (int s = 0; s < SETS; s++) exp_q.push_back(s);
        @(negedge clk);
        rst = 1'b1;
        while (!done && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
            n_checks++;
            if ((incr & clr_cnt) | (clr_rst_stall & clr_flush_stall)) begin
                n_fail++;
                $display("FAIL pwr_exclusive: incr=%b clr=%b crs=%b cfs=%b required no overlap",
                         incr, clr_cnt, clr_rst_stall, clr_flush_stall);
            end
            if (wr_set_inv) begin
                n_wr++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_checks++;
                if (int'(set_cnt) !== e) begin
                    n_fail++;
                    $display("FAIL pwr_set: got %0d expected %0d", set_cnt, e);
                end
                n_checks++;
                if (incr !== (e != SETS - 1)) begin
                    n_fail++;
                    $display("FAIL pwr_incr: got %b at set %0d", incr, e);
                end
                n_checks++;
                if ({clr_cnt, clr_rst_stall, walk_done} !== ((e == SETS - 1) ? 3'b111 : 3'b000)) begin
                    n_fail++;
                    $display("FAIL pwr_end_flags: got %b at set %0d", {clr_cnt, clr_rst_stall, walk_done}, e);
                end
                if (e == SETS - 1) done = 1'b1;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL pwr_timeout: walk_done got 0 expected 1");
        end
        n_checks++;
        if (n_wr !== SETS) begin
            n_fail++;
            $display("FAIL pwr_wr_count: got %0d expected %0d", n_wr, SETS);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (strobes !== 9'd0) begin
                n_fail++;
                $display("FAIL pwr_idle: got %b expected %b", strobes, 9'd0);
            end
        end
        n_checks++;
        if (rst_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL pwr_rst_stall: got %b expected 0", rst_stall);
        end
    endtask

    task automatic test_flush_clean();
        int n_rd = 0, n_cfs = 0, n_wb = 0, cyc = 0, guard = 0;
        bit started = 1'b0, done = 1'b0;
        for (int s = 0; s < SETS; s++) mem[s] = '0;
        while (!done && guard < 100) begin
            @(negedge clk);
            flush_req = (guard == 0);
            wb_ready  = 1'b1;
            #1;
            guard++;
            if (rd_set_req) begin
                n_checks++;
                if (int'(set_cnt) !== n_rd) begin
                    n_fail++;
                    $display("FAIL clean_rd_set: got %0d expected %0d", set_cnt, n_rd);
                end
                n_rd++;
                started = 1'b1;
            end
            if (started) cyc++;
            if (wb_valid) n_wb++;
            if (clr_flush_stall) begin
                n_cfs++;
                done = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        if (clr_flush_stall) n_cfs++;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL clean_timeout: clr_flush_stall got 0 expected 1");
        end
        n_checks++;
        if (n_rd !== SETS) begin
            n_fail++;
            $display("FAIL clean_rd_count: got %0d expected %0d", n_rd, SETS);
        end
        n_checks++;
        if (cyc !== 4 * SETS) begin
            n_fail++;
            $display("FAIL clean_cycles: got %0d expected %0d", cyc, 4 * SETS);
        end
        n_checks++;
        if (n_cfs !== 1) begin
            n_fail++;
            $display("FAIL clean_clr_flush: got %0d expected 1", n_cfs);
        end
        n_checks++;
        if (n_wb !== 0) begin
            n_fail++;
            $display("FAIL clean_wb: got %0d expected 0", n_wb);
        end
        n_checks++;
        if (flush_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_flush_stall: got %b expected 0", flush_stall);
        end
    endtask

    task automatic test_flush_dirty();
        int exp_q[$];
        int e, got;
        int n_inv = 0, n_rd = 0, cyc = 0, guard = 0;
        bit started = 1'b0, done = 1'b0;
        for (int s = 0; s < SETS; s++) mem[s] = '0;
        mem[2] = 16'h8005;
        while (!done && guard < 100) begin
            @(negedge clk);
            flush_req = (guard == 0);
            wb_ready  = 1'b1;
            #1;
            guard++;
            if (rd_set_req) begin
                n_rd++;
                started = 1'b1;
                for (int w = 0; w < WAYS; w++)
                    if (mem[set_cnt][w]) exp_q.push_back(int'(set_cnt) * 16 + w);
            end
            if (started) cyc++;
            n_checks++;
            if (wr_way_inv !== wb_valid) begin
                n_fail++;
                $display("FAIL dirty_inv_vs_valid: inv=%b expected %b", wr_way_inv, wb_valid);
            end
            if (wr_way_inv) begin
                got = int'(set_cnt) * 16 + int'(wb_way);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_inv++;
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL dirty_wb: got set%0d/way%0d expected code %0d", set_cnt, wb_way, e);
                end
            end
            if (clr_flush_stall) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL dirty_timeout: clr_flush_stall got 0 expected 1");
        end
        n_checks++;
        if (n_inv !== 3) begin
            n_fail++;
            $display("FAIL dirty_inv_count: got %0d expected 3", n_inv);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL dirty_leftover: got %0d expected 0", exp_q.size());
        end
        n_checks++;
        if (cyc !== 4 * SETS + 6) begin
            n_fail++;
            $display("FAIL dirty_cycles: got %0d expected %0d", cyc, 4 * SETS + 6);
        end
    endtask

    task automatic test_backpressure();
        int exp_q[$];
        int e, got;
        int v3 = 0, inv3 = 0, n_inv = 0, cyc = 0, guard = 0;
        bit started = 1'b0, done = 1'b0;
        for (int s = 0; s < SETS; s++) mem[s] = '0;
        mem[4] = 16'h0028;
        while (!done && guard < 100) begin
            @(negedge clk);
            flush_req = (guard == 0);
            wb_ready  = !(wb_valid && wb_way == 4'd3 && v3 < 5);
            #1;
            guard++;
            if (rd_set_req) begin
                started = 1'b1;
                for (int w = 0; w < WAYS; w++)
                    if (mem[set_cnt][w]) exp_q.push_back(int'(set_cnt) * 16 + w);
            end
            if (started) cyc++;
            if (wb_valid && wb_way == 4'd3) begin
                v3++;
                n_checks++;
                if (wr_way_inv !== (v3 == 6)) begin
                    n_fail++;
                    $display("FAIL bp_inv_timing: got %b at stall cycle %0d", wr_way_inv, v3);
                end
                if (wr_way_inv) inv3++;
            end
            if (wr_way_inv) begin
                got = int'(set_cnt) * 16 + int'(wb_way);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_inv++;
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL bp_wb: got set%0d/way%0d expected code %0d", set_cnt, wb_way, e);
                end
            end
            if (clr_flush_stall) done = 1'b1;
        end
        wb_ready = 1'b1;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL bp_timeout: clr_flush_stall got 0 expected 1");
        end
        n_checks++;
        if (v3 !== 6) begin
            n_fail++;
            $display("FAIL bp_valid_cycles: got %0d expected 6", v3);
        end
        n_checks++;
        if (inv3 !== 1) begin
            n_fail++;
            $display("FAIL bp_inv3: got %0d expected 1", inv3);
        end
        n_checks++;
        if (n_inv !== 2) begin
            n_fail++;
            $display("FAIL bp_inv_count: got %0d expected 2", n_inv);
        end
        n_checks++;
        if (cyc !== 4 * SETS + 9) begin
            n_fail++;
            $display("FAIL bp_cycles: got %0d expected %0d", cyc, 4 * SETS + 9);
        end
    endtask

    task automatic test_rst_state();
        int exp_q[$];
        int e;
        int phase = 0, wb_cnt = 0, n_wr = 0, n_inv = 0, guard = 0;
        bit done = 1'b0;
        for (int s = 0; s < SETS; s++) mem[s] = '0;
        mem[5] = 16'h0300;
        while (!done && guard < 150) begin
            @(negedge clk);
            flush_req = (guard == 0);
            wb_ready  = 1'b0;
            rst_state = (phase == 0 && wb_cnt == 2);
            #1;
            guard++;
            if (wr_way_inv) n_inv++;
            if (phase == 0) begin
                if (rst_state) begin
                    n_checks++;
                    if (strobes !== 9'd0) begin
                        n_fail++;
                        $display("FAIL rs_abort_cycle: got %b expected %b", strobes, 9'd0);
                    end
                    phase = 1;
                    for (int s = 0; s < SETS; s++) exp_q.push_back(s);
                end else if (wb_valid && set_cnt == 3'd5) begin
                    wb_cnt++;
                    n_checks++;
                    if (wb_way !== 4'd8) begin
                        n_fail++;
                        $display("FAIL rs_wb_way: got %0d expected 8", wb_way);
                    end
                end
            end else if (phase == 1) begin
                n_checks++;
                if (wb_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rs_wb_drop: got %b expected 0", wb_valid);
                end
                phase = 2;
            end else begin
                n_checks++;
                if (rd_set_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rs_no_read: got %b expected 0", rd_set_req);
                end
                if (wr_set_inv) begin
                    n_wr++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    n_checks++;
                    if (int'(set_cnt) !== e) begin
                        n_fail++;
                        $display("FAIL rs_walk_set: got %0d expected %0d", set_cnt, e);
                    end
                end
                if (walk_done) done = 1'b1;
            end
        end
        rst_state = 1'b0;
        wb_ready  = 1'b1;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL rs_timeout: walk_done got 0 expected 1 (phase %0d)", phase);
        end
        n_checks++;
        if (n_wr !== SETS) begin
            n_fail++;
            $display("FAIL rs_walk_count: got %0d expected %0d", n_wr, SETS);
        end
        n_checks++;
        if (n_inv !== 0) begin
            n_fail++;
            $display("FAIL rs_inv_count: got %0d expected 0", n_inv);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (strobes !== 9'd0) begin
            n_fail++;
            $display("FAIL rs_idle: got %b expected %b", strobes, 9'd0);
        end
    endtask

    task automatic test_flush_during_rst();
        int n_rd = 0, n_cfs = 0, wd_cyc = -1, rd_cyc = -1, guard = 0;
        bit flush_sent = 1'b0, kick = 1'b0, done = 1'b0, walk_seen = 1'b0;
        for (int s = 0; s < SETS; s++) mem[s] = '0;
        while (!done && guard < 150) begin
            @(negedge clk);
            rst_state = (guard == 0);
            flush_req = kick;
            if (kick) flush_sent = 1'b1;
            kick = 1'b0;
            #1;
            guard++;
            if (wr_set_inv && set_cnt == 3'd3 && !flush_sent) kick = 1'b1;
            if (walk_done && !walk_seen) begin
                walk_seen = 1'b1;
                wd_cyc = guard;
                n_checks++;
                if (clr_rst_stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fdr_clr_rst: got %b expected 1", clr_rst_stall);
                end
            end
            if (rd_set_req) begin
                n_checks++;
                if (!walk_seen) begin
                    n_fail++;
                    $display("FAIL fdr_early_read: read before walk_done at set %0d", set_cnt);
                end
                if (n_rd == 0) rd_cyc = guard;
                n_rd++;
            end
            if (clr_flush_stall) begin
                n_cfs++;
                done = 1'b1;
            end
        end
        rst_state = 1'b0;
        flush_req = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL fdr_timeout: clr_flush_stall got 0 expected 1");
        end
        n_checks++;
        if (rd_cyc - wd_cyc !== 2) begin
            n_fail++;
            $display("FAIL fdr_start_gap: got %0d expected 2", rd_cyc - wd_cyc);
        end
        n_checks++;
        if (n_rd !== SETS) begin
            n_fail++;
            $display("FAIL fdr_rd_count: got %0d expected %0d", n_rd, SETS);
        end
        n_checks++;
        if (n_cfs !== 1) begin
            n_fail++;
            $display("FAIL fdr_clr_flush: got %0d expected 1", n_cfs);
        end
    endtask

    initial begin
        for (int s = 0; s < SETS; s++) mem[s] = '0;
        test_reset();
        test_power_on();
        test_flush_clean();
        test_flush_dirty();
        test_backpressure();
        test_rst_state();
        test_flush_during_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
